tag_array_assoc: RTL and testbench

- Parametrised N-way set-associative tag store for the data cache; successor to the direct-mapped tag memory.
- Holds tag, valid and dirty per way per set. Returns registered hit/way plus victim selection for the cache controller.
- Adds a multi-cycle invalidate-all (flush) sequencer.
- Sits between the cache controller FSM and the data array; the way index it produces addresses the data array.

---
 rtl/memory_sub_system_param_pkg.sv | 23 ++
 rtl/tag_array_assoc_repl.sv | 95 +++++++++
 rtl/tag_array_assoc.sv | 157 +++++++++++++++
 tb/tb_tag_array_assoc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_sub_system_param_pkg.sv
// Shared memory-subsystem parameters and types for the data-cache tag store.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package memory_sub_system_param;

    localparam int INDEX_LENGTH     = 4;
    localparam int TAG_LENGTH       = 8;
    localparam int DEFAULT_NUM_WAYS = 4;

    // One tag-store entry as the cache controller sees it.
    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_LENGTH-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DONE
    } flush_state_t;

endpackage

// File: rtl/tag_array_assoc_repl.sv
// Per-set replacement state: tree pseudo-LRU (TAG_ARRAY_PLRU_EN) or round-robin pointer.
// Latency: victim is combinational from state; touch/clear take effect next cycle.
// Backpressure: none; the owner serialises clear and touch.
// Ports: clk/resetn; clear/clear_index zero one set; touch/touch_fill/touch_index/touch_way
//        record an access; victim_index/victim_way read the replacement choice.
module tag_repl_policy #(
    parameter  int INDEX_LEN = 4,
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_LEN   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic [INDEX_LEN-1:0] clear_index,
    input  logic                 touch,
    input  logic                 touch_fill,
    input  logic [INDEX_LEN-1:0] touch_index,
    input  logic [WAY_LEN-1:0]   touch_way,
    input  logic [INDEX_LEN-1:0] victim_index,
    output logic [WAY_LEN-1:0]   victim_way
);
    localparam int SETS = 2 ** INDEX_LEN;

`ifdef TAG_ARRAY_PLRU_EN
    // Heap-ordered tree: node n (1-based) lives in bit n-1, children are 2n and 2n+1.
    // A bit of 1 means "victim is in the right subtree".
    localparam int TREE = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    logic [TREE-1:0] tree_q [SETS];
    logic            plru_unused;

    function automatic logic [WAY_LEN-1:0] tree_victim(input logic [TREE-1:0] t);
        int              node;
        logic [TREE-1:0] sh;
        node = 1;
        if (NUM_WAYS == 1) return '0;
        for (int l = 0; l < WAY_LEN; l++) begin
            sh   = t >> (node - 1);
            node = 2 * node + int'(sh[0]);
        end
        return WAY_LEN'(node - NUM_WAYS);
    endfunction

    // Walk root to leaf along the touched way and point every node away from it.
    function automatic logic [TREE-1:0] tree_touch(input logic [TREE-1:0] t,
                                                    input logic [WAY_LEN-1:0] way);
        int                 node;
        logic [WAY_LEN-1:0] wsh;
        logic [TREE-1:0]    mask;
        logic [TREE-1:0]    res;
        node = 1;
        res  = t;
        if (NUM_WAYS == 1) return t;
        for (int l = 0; l < WAY_LEN; l++) begin
            wsh  = way >> (WAY_LEN - 1 - l);
            mask = TREE'(1) << (node - 1);
            if (wsh[0]) res = res & ~mask;
            else        res = res | mask;
            node = 2 * node + int'(wsh[0]);
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (clear) begin
            tree_q[clear_index] <= '0;
        end else if (touch) begin
            tree_q[touch_index] <= tree_touch(tree_q[touch_index], touch_way);
        end
    end

    assign victim_way  = tree_victim(tree_q[victim_index]);
    // Hits and fills update the tree identically.
    assign plru_unused = touch_fill;
`else
    logic [WAY_LEN-1:0] ptr_q [SETS];

    // Advance only when the pointed-to way is filled; hits leave the pointer alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (clear) begin
            ptr_q[clear_index] <= '0;
        end else if (touch && touch_fill && (touch_way == ptr_q[touch_index])) begin
            ptr_q[touch_index] <= (ptr_q[touch_index] == WAY_LEN'(NUM_WAYS - 1)) ?
                                  '0 : ptr_q[touch_index] + 1'b1;
        end
    end

    assign victim_way = ptr_q[victim_index];
`endif

endmodule

// File: rtl/tag_array_assoc.sv
// N-way set-associative tag store with registered lookup, victim select and flush sequencer.
// Latency: lookup result 1 cycle after request; flush takes 2**INDEX_LEN cycles + done pulse.
// Backpressure: ready low while flushing or in reset; inputs ignored while ready is low.
// Ports: lkp_* lookup request, rsp_* registered result (hit way or victim way on miss),
//        fill_*/mark_dirty install or dirty an entry, flush_req/flush_done invalidate-all.
// Build option: TAG_ARRAY_PLRU_EN selects tree pseudo-LRU instead of round-robin.
module tag_array_assoc
    import memory_sub_system_param::*;
#(
    parameter  int INDEX_LEN = INDEX_LENGTH,
    parameter  int TAG_LEN   = TAG_LENGTH,
    parameter  int NUM_WAYS  = DEFAULT_NUM_WAYS,
    localparam int WAY_LEN   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 ready,
    input  logic                 lkp_req,
    input  logic [INDEX_LEN-1:0] lkp_index,
    input  logic [TAG_LEN-1:0]   lkp_tag,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [WAY_LEN-1:0]   rsp_way,
    output logic                 rsp_victim_valid,
    output logic                 rsp_victim_dirty,
    output logic [TAG_LEN-1:0]   rsp_victim_tag,
    input  logic                 fill_req,
    input  logic [INDEX_LEN-1:0] fill_index,
    input  logic [WAY_LEN-1:0]   fill_way,
    input  logic [TAG_LEN-1:0]   fill_tag,
    input  logic                 fill_dirty,
    input  logic                 mark_dirty,
    input  logic                 flush_req,
    output logic                 flush_done
);
    localparam int SETS = 2 ** INDEX_LEN;
    localparam logic [INDEX_LEN-1:0] LAST_SET = INDEX_LEN'(SETS - 1);

    flush_state_t         state_q;
    logic [INDEX_LEN-1:0] flush_cnt_q;
    logic [NUM_WAYS-1:0]  valid_q [SETS];
    logic [NUM_WAYS-1:0]  dirty_q [SETS];
    logic [TAG_LEN-1:0]   tag_q   [SETS][NUM_WAYS];

    logic               do_flush, do_fill, do_mark, do_lkp;
    logic               lkp_hit, inv_found;
    logic [WAY_LEN-1:0] hit_way, inv_way, victim_way, sel_way;

    // DONE is the completion cycle: the array is already clean, so traffic is accepted.
    assign ready    = resetn && (state_q != FLUSH);
    assign do_flush = ready && flush_req;
    assign do_fill  = ready && !flush_req && fill_req;
    assign do_mark  = ready && !flush_req && !fill_req && mark_dirty;
    assign do_lkp   = ready && !flush_req && !fill_req && !mark_dirty && lkp_req;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        lkp_hit   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lkp_index][w] && (tag_q[lkp_index][w] == lkp_tag)) begin
                lkp_hit = 1'b1;
                hit_way = WAY_LEN'(w);
            end
            if (!valid_q[lkp_index][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_LEN'(w);
            end
        end
    end

    assign sel_way = lkp_hit ? hit_way : (inv_found ? inv_way : victim_way);

    tag_repl_policy #(
        .INDEX_LEN (INDEX_LEN),
        .NUM_WAYS  (NUM_WAYS)
    ) u_repl (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (state_q == FLUSH),
        .clear_index  (flush_cnt_q),
        .touch        (do_fill || (do_lkp && lkp_hit)),
        .touch_fill   (do_fill),
        .touch_index  (do_fill ? fill_index : lkp_index),
        .touch_way    (do_fill ? fill_way : hit_way),
        .victim_index (lkp_index),
        .victim_way   (victim_way)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[flush_cnt_q] <= '0;
            dirty_q[flush_cnt_q] <= '0;
        end else if (do_fill) begin
            valid_q[fill_index][fill_way] <= 1'b1;
            dirty_q[fill_index][fill_way] <= fill_dirty;
        end else if (do_mark) begin
            dirty_q[fill_index][fill_way] <= 1'b1;
        end
    end

    // Tag contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_fill) tag_q[fill_index][fill_way] <= fill_tag;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            flush_done       <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state_q)
                FLUSH: begin
                    if (flush_cnt_q == LAST_SET) begin
                        state_q    <= DONE;
                        flush_done <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (do_flush) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase

            rsp_valid <= do_lkp;
            if (do_lkp) begin
                rsp_hit          <= lkp_hit;
                rsp_way          <= sel_way;
                rsp_victim_valid <= valid_q[lkp_index][sel_way];
                rsp_victim_dirty <= dirty_q[lkp_index][sel_way];
                rsp_victim_tag   <= tag_q[lkp_index][sel_way];
            end
        end
    end

endmodule

// File: tb/tb_tag_array_assoc.sv
// Directed bench for tag_array_assoc (INDEX_LEN 4, TAG_LEN 8, NUM_WAYS 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_tag_array_assoc;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ready;
    logic       lkp_req;
    logic [3:0] lkp_index;
    logic [7:0] lkp_tag;
    logic       rsp_valid, rsp_hit;
    logic [1:0] rsp_way;
    logic       rsp_victim_valid, rsp_victim_dirty;
    logic [7:0] rsp_victim_tag;
    logic       fill_req;
    logic [3:0] fill_index;
    logic [1:0] fill_way;
    logic [7:0] fill_tag;
    logic       fill_dirty;
    logic       mark_dirty;
    logic       flush_req;
    logic       flush_done;

    int vectors     = 0;
    int miscompares = 0;
    logic excl_viol = 1'b0;

    always #5 clk = ~clk;

    tag_array_assoc #(.INDEX_LEN(4), .TAG_LEN(8), .NUM_WAYS(4)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ready            (ready),
        .lkp_req          (lkp_req),
        .lkp_index        (lkp_index),
        .lkp_tag          (lkp_tag),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_way          (rsp_way),
        .rsp_victim_valid (rsp_victim_valid),
        .rsp_victim_dirty (rsp_victim_dirty),
        .rsp_victim_tag   (rsp_victim_tag),
        .fill_req         (fill_req),
        .fill_index       (fill_index),
        .fill_way         (fill_way),
        .fill_tag         (fill_tag),
        .fill_dirty       (fill_dirty),
        .mark_dirty       (mark_dirty),
        .flush_req        (flush_req),
        .flush_done       (flush_done)
    );

    // fill_req and mark_dirty must never be driven together.
    always @(posedge clk) begin
        if (fill_req && mark_dirty) excl_viol <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        lkp_req = 1'b0; fill_req = 1'b0; mark_dirty = 1'b0; flush_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic fill(input logic [3:0] idx, input logic [1:0] way,
                        input logic [7:0] tag, input logic dirty);
        step();
        fill_req = 1'b1; fill_index = idx; fill_way = way; fill_tag = tag; fill_dirty = dirty;
    endtask

    task automatic mark(input logic [3:0] idx, input logic [1:0] way);
        step();
        mark_dirty = 1'b1; fill_index = idx; fill_way = way;
    endtask

    // Returns at the negedge after the sampling edge, with rsp_* showing the result.
    task automatic lookup(input logic [3:0] idx, input logic [7:0] tag);
        step();
        lkp_req = 1'b1; lkp_index = idx; lkp_tag = tag;
        step();
    endtask

    int   low_cycles;
    int   done_cycle;
    int   done_seen;
    logic exp_way1, exp_vdirty;
    logic [1:0] exp_vway;
    logic [7:0] exp_vtag;

    initial begin
        clear_inputs();
        lkp_index = '0; lkp_tag = '0; fill_index = '0; fill_way = '0;
        fill_tag = '0; fill_dirty = 1'b0;
        resetn = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_way", rsp_way, 0);
        chk("rst_victim_valid", rsp_victim_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        resetn = 1'b1;
        #1;
        chk("rst_release_ready", ready, 1);

        // Cold miss picks first invalid way
        lookup(4'd3, 8'h5A);
        chk("cold_valid", rsp_valid, 1);
        chk("cold_hit", rsp_hit, 0);
        chk("cold_way", rsp_way, 0);
        chk("cold_vvalid", rsp_victim_valid, 0);

        // Fill followed immediately by a lookup to the same set sees the new tag
        fill(4'd3, 2'd2, 8'h5A, 1'b0);
        lookup(4'd3, 8'h5A);
        chk("fill_hit", rsp_hit, 1);
        chk("fill_way", rsp_way, 2);
        chk("fill_vtag", rsp_victim_tag, 8'h5A);
        chk("fill_vdirty", rsp_victim_dirty, 0);
        step();
        chk("hold_valid_drop", rsp_valid, 0);
        chk("hold_way", rsp_way, 2);
        lookup(4'd4, 8'h5A);
        chk("other_set_hit", rsp_hit, 0);
        chk("other_set_way", rsp_way, 0);
        lookup(4'd3, 8'h99);
        chk("partial_miss_way", rsp_way, 0);
        chk("partial_miss_vvalid", rsp_victim_valid, 0);

        // Full set: victim comes from the replacement policy
        for (int w = 0; w < 4; w++) fill(4'd7, 2'(w), 8'h10 + 8'(w), 1'b0);
        mark(4'd7, 2'd1);
        lookup(4'd7, 8'h10); chk("set7_hit0", rsp_way, 0);
        lookup(4'd7, 8'h12); chk("set7_hit2", rsp_way, 2);
        lookup(4'd7, 8'h13); chk("set7_hit3", rsp_way, 3);
        lookup(4'd7, 8'h11); chk("set7_hit1_dirty", rsp_victim_dirty, 1);
`ifdef TAG_ARRAY_PLRU_EN
        // The hit on way 1 above moved it to MRU; hitting 0,2,3 again leaves way 1 oldest.
        lookup(4'd7, 8'h10);
        lookup(4'd7, 8'h12);
        lookup(4'd7, 8'h13);
        exp_vway = 2'd1; exp_vdirty = 1'b1; exp_vtag = 8'h11;
`else
        exp_vway = 2'd0; exp_vdirty = 1'b0; exp_vtag = 8'h10;
`endif
        exp_way1 = 1'b0;
        lookup(4'd7, 8'h55);
        chk("victim_hit", rsp_hit, exp_way1);
        chk("victim_way", rsp_way, exp_vway);
        chk("victim_valid", rsp_victim_valid, 1);
        chk("victim_dirty", rsp_victim_dirty, exp_vdirty);
        chk("victim_tag", rsp_victim_tag, exp_vtag);

        // Flush: ready low 16 cycles, done pulse on cycle 17
        step();
        flush_req = 1'b1;
        low_cycles = 0; done_cycle = 0; done_seen = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (flush_done) begin done_cycle = cyc; done_seen++; end
            if (!ready) low_cycles++;
            else break;
        end
        chk("flush_low_cycles", low_cycles, 16);
        chk("flush_done_cycle", done_cycle, 17);
        step();
        chk("flush_done_pulse", flush_done, 0);
        chk("flush_done_count", done_seen, 1);
        lookup(4'd3, 8'h5A);
        chk("post_flush_hit_s3", rsp_hit, 0);
        chk("post_flush_vvalid_s3", rsp_victim_valid, 0);
        lookup(4'd7, 8'h10);
        chk("post_flush_hit_s7", rsp_hit, 0);
        chk("post_flush_way_s7", rsp_way, 0);
        chk("post_flush_vvalid_s7", rsp_victim_valid, 0);

        // Reset in the middle of a flush
        fill(4'd3, 2'd0, 8'h21, 1'b1);
        step();
        flush_req = 1'b1;
        step();
        repeat (4) step();
        resetn = 1'b0;
        #1;
        chk("midflush_rst_ready", ready, 0);
        chk("midflush_rst_done", flush_done, 0);
        step();
        resetn = 1'b1;
        #1;
        chk("midflush_release_ready", ready, 1);
        done_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if (flush_done) done_seen++;
        end
        chk("midflush_no_done", done_seen, 0);
        lookup(4'd3, 8'h21);
        chk("midflush_hit", rsp_hit, 0);
        chk("midflush_vvalid", rsp_victim_valid, 0);

        // Same-cycle fill and lookup: fill wins, lookup dropped
        step();
        fill_req = 1'b1; fill_index = 4'd3; fill_way = 2'd1; fill_tag = 8'h77; fill_dirty = 1'b0;
        lkp_req = 1'b1; lkp_index = 4'd3; lkp_tag = 8'h77;
        step();
        chk("same_cycle_dropped", rsp_valid, 0);
        lkp_req = 1'b1; lkp_index = 4'd3; lkp_tag = 8'h77;
        step();
        chk("same_cycle_next_valid", rsp_valid, 1);
        chk("same_cycle_next_hit", rsp_hit, 1);
        chk("same_cycle_next_way", rsp_way, 1);

        chk("fill_mark_exclusive", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
